// File: rtl/img_sched_pkg.sv
// Shared types and constants for the image-engine job scheduler.
package img_sched_pkg;

  localparam int IMG_DIM = 64;

  typedef enum logic [1:0] {
    OP_BLUR    = 2'd0,
    OP_MIRROR  = 2'd1,
    OP_ROTATE  = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    SWAP,
    ABORT
  } state_e;

  // Queue entry: engine op plus the "swap banks when finished" flag.
  typedef struct packed {
    logic [1:0] op;
    logic       chain;
  } job_t;

endpackage

// File: rtl/job_fifo.sv
// Small synchronous FIFO with flush; head entry is readable without a pop.
module job_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic [W-1:0] mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rd_q[AW-1:0]];
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/img_job_sched.sv
// Issues queued jobs to the image engine one at a time, ping-pongs the image
// banks on chained completions and aborts jobs that overrun the watchdog.
module img_job_sched
  import img_sched_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 32768,
  parameter int TMR_W       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_valid,
  input  logic [1:0]  job_op,
  input  logic        job_chain,
  output logic        job_ready,
  output logic        eng_start,
  output logic [1:0]  eng_op,
  input  logic        eng_done,
  output logic        eng_abort,
  output logic        rd_bank,
  output logic        wr_bank,
  output logic        busy,
  output logic        job_done,
  output logic [15:0] jobs_done,
  output logic        err_op,
  output logic        err_timeout,
  input  logic        err_clr
);

  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic        eng_start_q, eng_start_d;
  logic [1:0]  eng_op_q, eng_op_d;
  logic        eng_abort_q, eng_abort_d;
  logic        job_done_q, job_done_d;
  logic        chain_q, chain_d;
  logic        buf_sel_q, buf_sel_d;
  logic [TMR_W-1:0] wd_q, wd_d;
  logic [15:0] jobs_done_q, jobs_done_d;
  logic        err_op_q, err_op_d;
  logic        err_to_q, err_to_d;

  logic fifo_full;
  logic fifo_empty;
  logic handshake;
  job_t wjob;
  job_t head;

  assign handshake = job_valid && job_ready;
  assign wjob      = '{op: job_op, chain: job_chain};

  job_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(job_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (handshake && (job_op != OP_ILLEGAL)),
    .pop   (state_q == ISSUE),
    .flush (state_q == ABORT),
    .wdata (wjob),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    eng_start_d = 1'b0;
    eng_abort_d = 1'b0;
    job_done_d  = 1'b0;
    eng_op_d    = eng_op_q;
    chain_d     = chain_q;
    buf_sel_d   = buf_sel_q;
    wd_d        = wd_q;
    jobs_done_d = jobs_done_q;
    err_op_d    = err_op_q & ~err_clr;
    err_to_d    = err_to_q & ~err_clr;

    if (handshake && (job_op == OP_ILLEGAL)) err_op_d = 1'b1;

    // Registered outputs are loaded on entry so they are valid in the state itself.
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d     = ISSUE;
          eng_start_d = 1'b1;
          eng_op_d    = head.op;
          chain_d     = head.chain;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wd_d = wd_q + TMR_W'(1);
        // wd_q == 0 marks the first WAIT cycle, where eng_done may still be stale.
        if ((wd_q != '0) && eng_done) begin
          state_d    = SWAP;
          job_done_d = 1'b1;
        end else if (wd_q == TMO_LAST) begin
          state_d     = ABORT;
          eng_abort_d = 1'b1;
          err_to_d    = 1'b1;
        end
      end
      SWAP: begin
        jobs_done_d = jobs_done_q + 16'd1;
        if (chain_q) buf_sel_d = ~buf_sel_q;
        state_d = IDLE;
      end
      ABORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      eng_start_q <= 1'b0;
      eng_op_q    <= 2'd0;
      eng_abort_q <= 1'b0;
      job_done_q  <= 1'b0;
      chain_q     <= 1'b0;
      buf_sel_q   <= 1'b0;
      wd_q        <= '0;
      jobs_done_q <= 16'd0;
      err_op_q    <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      eng_start_q <= eng_start_d;
      eng_op_q    <= eng_op_d;
      eng_abort_q <= eng_abort_d;
      job_done_q  <= job_done_d;
      chain_q     <= chain_d;
      buf_sel_q   <= buf_sel_d;
      wd_q        <= wd_d;
      jobs_done_q <= jobs_done_d;
      err_op_q    <= err_op_d;
      err_to_q    <= err_to_d;
    end
  end

  assign job_ready   = !fifo_full;
  assign busy        = (state_q != IDLE) || !fifo_empty;
  assign rd_bank     = buf_sel_q;
  assign wr_bank     = ~buf_sel_q;
  assign eng_start   = eng_start_q;
  assign eng_op      = eng_op_q;
  assign eng_abort   = eng_abort_q;
  assign job_done    = job_done_q;
  assign jobs_done   = jobs_done_q;
  assign err_op      = err_op_q;
  assign err_timeout = err_to_q;

endmodule

// File: doc/img_job_sched.md
# img_job_sched

Job scheduler in front of the 64×64 image-processing engine (blur / mirror / rotate). It accepts operation requests from the host into a small queue and issues them to the engine one at a time. It waits for the engine's `done`, ping-pongs the two image banks so chained operations feed each other, and watchdogs each job with a timeout.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: job queue entries (power of two, ≥2).
- `TIMEOUT_CYC`, 32768: max WAIT cycles per job before abort.
- `TMR_W`, 16: watchdog counter width; must hold `TIMEOUT_CYC-1`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `job_valid`  in  1  host offers a job this cycle.
- `job_op`  in  2  0 blur, 1 mirror, 2 rotate, 3 illegal.
- `job_chain`  in  1  1: this job's output becomes the next job's input (swap banks on completion).
- `job_ready`  out  1  = !fifo_full; transfer when `job_valid & job_ready`.
- `eng_start`  out  1  one-cycle pulse launching the engine.
- `eng_op`  out  2  op for the engine, held stable from ISSUE until the next ISSUE.
- `eng_done`  in  1  engine completion level; may stay high until the next start.
- `eng_abort`  out  1  one-cycle pulse on timeout.
- `rd_bank`  out  1  bank the engine reads (= `buf_sel`).
- `wr_bank`  out  1  bank the engine writes (= `~buf_sel`).
- `busy`  out  1  state ≠ IDLE or queue non-empty.
- `job_done`  out  1  one-cycle pulse per successfully completed job.
- `jobs_done`  out  16  completed-job counter, wraps 0xFFFF→0.
- `err_op`  out  1  sticky: illegal op offered.
- `err_timeout`  out  1  sticky: watchdog fired.
- `err_clr`  in  1  clears both sticky errors.

## Operation
- Reset values:
  - `eng_start`, `eng_abort`, `job_done`: 0.
  - `eng_op`: 0.
  - `buf_sel`: 0, so `rd_bank` = 0 and `wr_bank` = 1.
  - `busy`: 0.
  - `jobs_done`: 0.
  - `err_op`, `err_timeout`: 0.
  - Queue empty, so `job_ready` = 1.
  - State IDLE.
- Enqueue: a handshake with `job_op` ≠ 3 writes {op, chain} into the FIFO.
- Illegal op: a handshake with `job_op` = 3 consumes the job, does not enqueue it, and sets `err_op`.
- Full queue: no bypass. `job_ready` is 0 while full, even in a cycle where ISSUE pops.
- States:
  - IDLE: queue non-empty → ISSUE.
  - ISSUE (1 cycle): `eng_start`=1; `eng_op` ← head op; latch head chain bit; pop; watchdog ← 0; → WAIT.
  - WAIT: the first WAIT cycle ignores `eng_done` (stale level guard). After that, `eng_done`=1 → SWAP.
  - WAIT timeout: watchdog = `TIMEOUT_CYC-1` → ABORT. If `eng_done` and timeout coincide, done wins.
  - SWAP (1 cycle): `job_done`=1; `jobs_done`++; if latched chain = 1, toggle `buf_sel`; → IDLE.
  - ABORT (1 cycle): `eng_abort`=1; set `err_timeout`; flush FIFO; no swap, no count; → IDLE.
- `err_clr` coinciding with a new error: the set wins.
- Reset mid-job: all state returns to reset values immediately (async). Queued jobs are lost, and the engine is not aborted explicitly.

## Timing
- Accept in cycle c with queue empty and IDLE → `eng_start` high in cycle c+2.
- `eng_done` sampled high in WAIT cycle d:
  - `job_done` pulses in cycle d+1.
  - `jobs_done` and banks update at the end of d+1.
  - Next `eng_start` no earlier than cycle d+3.
- Watchdog counts every WAIT cycle. The abort pulse occurs `TIMEOUT_CYC`+1 cycles after the ISSUE cycle.
- All outputs are registered except `job_ready`, `busy`, `rd_bank` and `wr_bank`, which are combinational from registers.

## Structure
- Package `img_sched_pkg`:
  - Op codes `OP_BLUR`, `OP_MIRROR`, `OP_ROTATE`, `OP_ILLEGAL`.
  - State enum `{IDLE, ISSUE, WAIT, SWAP, ABORT}`.
  - `IMG_DIM = 64`.
- Sub-module `job_fifo`: synchronous FIFO, 3-bit entries, `FIFO_DEPTH` deep, with push/pop/flush and full/empty. The FSM, watchdog, bank select and counters live in the top.

## Test plan
- Reset, push blur (chain=1), engine model asserts done 10 cycles after start:
  - `eng_start` at c+2 with `eng_op`=0.
  - `job_done` pulse.
  - `jobs_done`=1.
  - `rd_bank`=1, `wr_bank`=0.
- Push mirror(chain=1), rotate(chain=0), blur(chain=1) back-to-back:
  - Three starts in order with ops 1, 2, 0.
  - Final `buf_sel`=0.
  - `jobs_done`=3.
  - Start spacing ≥3 cycles after each done.
- Push 5 jobs with FIFO_DEPTH=4 while the engine is stalled: `job_ready` drops after 4 accepted (one already issued leaves room for the 5th only after pop), and no job is dropped.
- Offer op 3, then `err_clr`:
  - Nothing issued.
  - `err_op`=1 until clear.
  - `busy` stays 0.
- TIMEOUT_CYC=16, engine never done, 2 jobs queued:
  - `eng_abort` pulse at ISSUE+17.
  - `err_timeout`=1.
  - Queue flushed, no further start.
  - `jobs_done` unchanged, banks unchanged.
- Assert `rst_n`=0 mid-WAIT with 2 jobs queued: all outputs return to reset values in the same cycle, and no start occurs after release until a new push.
